// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM state type and request legality check
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FAULT} lsu_state_t;

    // Stores only know B/H/W; loads add the unsigned B/H variants.
    function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [1:0] lo);
        logic illegal;
        logic misaligned;
        illegal    = we ? (f3[2] || f3[1:0] == 2'b11)
                        : (f3[1:0] == 2'b11 || f3 == 3'b110);
        misaligned = (f3[1:0] == 2'b01 && lo[0]) || (f3[1:0] == 2'b10 && lo != 2'b00);
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - lane select and sign/zero extension of a loaded word
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   result = {24'd0, shifted[7:0]};
            F3_HU:   result = {16'd0, shifted[15:0]};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding RV32I load/store stage with fault rejection
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        fault,
    output logic        busy
);

    lsu_state_t  state_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic [4:0]  rd_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        wb_valid_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;

    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] align_out;

    // Byte enables and lane replication are computed from the live request and captured on accept.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = req_wdata;
        if (req_we) begin
            case (req_funct3[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << req_addr[1:0];
                    wdata_d = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{req_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    load_align u_load_align (
        .rdata   (mem_rdata),
        .addr_lo (lo_q),
        .funct3  (f3_q),
        .result  (align_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            f3_q       <= 3'd0;
            lo_q       <= 2'd0;
            rd_q       <= 5'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
        end else begin
            wb_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    f3_q    <= req_funct3;
                    lo_q    <= req_addr[1:0];
                    rd_q    <= req_rd;
                    addr_q  <= {req_addr[31:2], 2'b00};
                    wdata_q <= wdata_d;
                    be_q    <= be_d;
                    state_q <= req_bad(req_we, req_funct3, req_addr[1:0]) ? FAULT : REQ;
                end
                REQ: if (mem_gnt) state_q <= we_q ? IDLE : WAIT;
                WAIT: if (mem_rvalid) begin
                    wb_valid_q <= 1'b1;
                    wb_rd_q    <= rd_q;
                    wb_data_q  <= align_out;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = !req_ready;
    assign mem_req   = (state_q == REQ);
    assign fault     = (state_q == FAULT);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and randomized bench with an arithmetic reference model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .fault(fault), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic bit m_fault(bit we, logic [2:0] f3, logic [31:0] a);
        int sz;
        bit legal;
        legal = we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
        if (!legal) return 1'b1;
        sz = 1 << (f3 % 4);
        return (a % sz) != 0;
    endfunction

    function automatic logic [3:0] m_be(bit we, logic [2:0] f3, logic [31:0] a);
        int sz;
        if (!we) return 4'hF;
        sz = 1 << (f3 % 4);
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] wd);
        case (f3 % 4)
            0:       return (wd % 256) * 32'h0101_0101;
            1:       return (wd % 65536) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
        longint lane, sz, bits, v;
        sz = 1 << (f3 % 4);
        if (sz == 4) return rd;
        bits = 8 * sz;
        lane = longint'(rd) / (longint'(1) << (8 * (a % 4)));
        v = lane % (longint'(1) << bits);
        if (f3 < 4 && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        return v[31:0];
    endfunction

    // One complete transaction: offer, wait out grant/rvalid stalls, check every observable beat.
    task automatic do_txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd, input int gnt_wait,
                          input int rv_wait, input bit rv_at_gnt, input logic [31:0] rdata,
                          output logic [31:0] got);
        bit exp_fault;
        exp_fault = m_fault(we, f3, a);
        got = 32'hx;
        chk("ready_before", req_ready, 1);
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
        step();
        req_valid = 0; req_we = $urandom; req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
        if (exp_fault) begin
            chk("fault_pulse", fault, 1);
            chk("fault_no_req", mem_req, 0);
            chk("fault_busy", busy, 1);
            step();
            chk("fault_clear", fault, 0);
            chk("fault_ready", req_ready, 1);
            chk("fault_no_req2", mem_req, 0);
            return;
        end
        for (int i = 0; i <= gnt_wait; i++) begin
            if (i == gnt_wait) begin
                mem_gnt = 1;
                mem_rvalid = rv_at_gnt;
                mem_rdata = $urandom;
            end
            chk("mem_req", mem_req, 1);
            chk("mem_we", mem_we, we);
            chk("mem_addr", mem_addr, {a[31:2], 2'b00});
            chk("mem_be", mem_be, m_be(we, f3, a));
            if (we) chk("mem_wdata", mem_wdata, m_wdata(f3, wd));
            chk("no_wb_req", wb_valid, 0);
            step();
        end
        mem_gnt = 0; mem_rvalid = 0;
        if (we) begin
            chk("st_ready", req_ready, 1);
            chk("st_no_req", mem_req, 0);
            chk("st_no_wb", wb_valid, 0);
            return;
        end
        for (int i = 0; i <= rv_wait; i++) begin
            if (i == rv_wait) begin
                mem_rvalid = 1;
                mem_rdata = rdata;
            end
            chk("wait_no_req", mem_req, 0);
            chk("wait_no_wb", wb_valid, 0);
            chk("wait_busy", busy, 1);
            step();
        end
        mem_rvalid = 0; mem_rdata = $urandom;
        chk("wb_valid", wb_valid, 1);
        chk("wb_rd", wb_rd, rd);
        chk("wb_data", wb_data, m_load(f3, a, rdata));
        chk("ld_ready", req_ready, 1);
        got = wb_data;
        step();
        chk("wb_pulse_end", wb_valid, 0);
    endtask

    logic [31:0] got;

    initial begin
        rst = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        step();
        step();
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_fault", fault, 0);
        rst = 0;
        step();

        do_txn(0, 3'b000, 32'h1003, 0, 5'd7, 0, 0, 0, 32'h80FF_1234, got);
        chk("lb_const", got, 32'hFFFF_FF80);
        do_txn(0, 3'b101, 32'h2002, 0, 5'd9, 0, 0, 0, 32'h8001_0000, got);
        chk("lhu_const", got, 32'h0000_8001);
        do_txn(0, 3'b001, 32'h2002, 0, 5'd10, 0, 0, 0, 32'h8001_0000, got);
        chk("lh_const", got, 32'hFFFF_8001);
        do_txn(1, 3'b000, 32'h3001, 32'hAABB_CCDD, 5'd0, 3, 0, 0, 0, got);
        do_txn(1, 3'b010, 32'h4002, 32'h1234_5678, 5'd0, 0, 0, 0, 0, got);
        do_txn(0, 3'b011, 32'h5000, 0, 5'd3, 0, 0, 0, 0, got);
        do_txn(0, 3'b010, 32'h6000, 0, 5'd12, 0, 2, 1, 32'hCAFE_F00D, got);
        chk("lw_rv_at_gnt", got, 32'hCAFE_F00D);

        // Reset while a load sits in WAIT: outputs drop immediately and the late rvalid is dropped.
        req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h7000; req_rd = 5'd5;
        step();
        req_valid = 0; mem_gnt = 1;
        step();
        mem_gnt = 0;
        chk("wait_busy_pre_rst", busy, 1);
        #2 rst = 1;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_wb_valid", wb_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", req_ready, 1);
        step();
        rst = 0; mem_rvalid = 1; mem_rdata = 32'h1111_2222;
        step();
        mem_rvalid = 0;
        chk("late_rv_no_wb", wb_valid, 0);
        chk("late_rv_ready", req_ready, 1);
        chk("late_rv_no_req", mem_req, 0);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            logic [2:0]  f3;
            a  = $urandom;
            f3 = 3'($urandom);
            do_txn(1'($urandom), f3, a, $urandom, 5'($urandom), $urandom_range(0, 2),
                   $urandom_range(0, 2), 1'($urandom), $urandom, got);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
